lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Downstream consumer of the LSU's LCD control register (address 0x1000_4xxx). It turns each software-issued command/data word into a correctly timed HD44780 bus transfer on the DE2 character-LCD pins. After reset it runs the power-up initialisation sequence on its own. A single-entry pending buffer absorbs back-to-back stores, and a busy flag is exported so software can poll it through the input buffer.

## Interface
Parameters (cycle counts assume a 50 MHz clock; each must be ≥ 1):
- PWRUP_CYC, 750000, wait after reset before the first init transfer (15 ms)
- SETUP_CYC, 3, RS/DATA valid before EN rises (t_AS)
- EN_CYC, 12, EN high width (≥ 230 ns)
- HOLD_CYC, 2, RS/DATA held after EN falls
- WAIT_CYC, 2000, execution wait for ordinary commands/data (40 µs)
- CLR_CYC, 82000, execution wait for clear/home, i.e. RS=0 with DATA 0x01, 0x02 or 0x03 (1.64 ms)
- CNT_W, 20, timer width; must hold the largest count

Ports:
- i_clk, input, 1, system clock
- i_reset_n, input, 1, reset; single clock domain, reset asynchronous and active-low
- i_io_lcd, input, 32, LSU LCD register: [7:0] byte, [8] RS, [10] GO, [11] OVF_CLR, [31] ON
- o_lcd_data, output, 8, LCD data bus
- o_lcd_rs, output, 1, register select
- o_lcd_rw, output, 1, read/write; tied 0 (write only)
- o_lcd_en, output, 1, enable strobe
- o_lcd_on, output, 1, panel power/backlight
- o_busy, output, 1, high while initialising, transferring, waiting, or holding a pending request
- o_overflow, output, 1, sticky; set when a request is dropped

## Operation
- Requests: GO edge detection. prev_go resets to 0. edge = i_io_lcd[10] & ~prev_go. On an edge, {RS, byte} is captured from the same cycle.
- FSM states:
  - PWRUP: timer counts PWRUP_CYC, then INIT transfer 0.
  - IDLE: waits for a request.
  - SETUP: EN=0, RS/DATA driven, SETUP_CYC cycles.
  - PULSE: EN=1, EN_CYC cycles.
  - HOLD: EN=0, HOLD_CYC cycles.
  - WAIT: WAIT_CYC or CLR_CYC cycles; the choice is made from the transfer's RS/byte.
- Init sequence: RS=0 bytes 0x38, 0x0C, 0x01, 0x06. A 2-bit index is incremented at each WAIT exit. After 0x06 completes, go to IDLE.
- Request dispatch:
  - IDLE + edge → SETUP with the captured word.
  - Edge in any other state → pending buffer if it is empty.
  - Edge with the pending buffer full → the request is dropped and o_overflow is set.
- WAIT exit:
  - Pending valid → SETUP with the pending word; pending is cleared.
  - Otherwise, an edge in that same cycle → SETUP directly with it.
  - Otherwise → IDLE.
- Edges during PWRUP/init are queued the same way and served after init.
- o_overflow clears while i_io_lcd[11]=1. If a set condition and a clear occur in the same cycle, set wins.
- o_lcd_on is i_io_lcd[31] registered once; it is independent of the FSM.
- Timer: loaded with N-1 on state entry, decremented each cycle; the state exits when it reaches 0. Each state therefore lasts exactly N cycles.

## Timing
- All outputs are registered.
- Reset values:
  - o_lcd_data=0x00, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0
  - o_busy=1, o_overflow=0
  - state=PWRUP, pending empty
- Sequence for a request accepted in IDLE (GO rises in the cycle after posedge T):
  - posedge T+1: SETUP is entered, data/RS appear and o_busy=1.
  - posedge T+1+SETUP_CYC: EN rises.
  - EN falls EN_CYC cycles later.
  - o_busy falls after HOLD_CYC+WAIT cycles, provided nothing is pending.
- Per-transfer occupancy is SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles.
- o_lcd_data/o_lcd_rs change only on SETUP entry and are stable through PULSE and HOLD.
- Reset assertion mid-transfer: EN drops immediately (asynchronously), pending is discarded and init restarts from PWRUP.
- o_busy=0 only in IDLE with pending empty.

## Test plan
Test parameters: SETUP_CYC=2, EN_CYC=3, HOLD_CYC=1, WAIT_CYC=5, CLR_CYC=20, PWRUP_CYC=10.
- Reset release, no stimulus:
  - EN=0 for 10 cycles, then four EN pulses of 3 cycles each.
  - Data sequence 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - Gap after 0x01 is ≥ 20 cycles.
  - o_busy falls exactly 69 cycles after release.
- Idle write of i_io_lcd=0x0000_0541 (GO, RS=1, 'A'):
  - Next posedge: data=0x41, rs=1, busy=1.
  - EN high on cycles +3..+5.
  - busy=0 after 11 cycles.
- Two GO edges 2 cycles apart (0x41, then 0x42):
  - Second transfer starts the cycle after the first WAIT ends.
  - busy stays 1 throughout; o_overflow=0.
- Three GO edges during a single transfer:
  - Third edge sets o_overflow=1 and only two transfers occur.
  - Writing bit 11 clears o_overflow on the next posedge.
- Clear command (RS=0, byte 0x01) followed by a queued request:
  - Next SETUP begins exactly 20 cycles after HOLD ends.
- i_reset_n pulsed low during PULSE:
  - EN=0 immediately, busy=1, pending empty.
  - Init sequence restarts.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: power-up init sequence, then software command/data transfers.
// Latency: a GO edge seen in IDLE enters SETUP (RS/DATA driven) on the next posedge; EN rises SETUP_CYC later.
// Backpressure: one request is buffered while busy; a further request is dropped and sets sticky o_overflow.
module lcd_hd44780_ctrl #(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned SETUP_CYC = 3,
  parameter int unsigned EN_CYC    = 12,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned WAIT_CYC  = 2000,
  parameter int unsigned CLR_CYC   = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overflow
);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  // Timer reload values: a state lasting N cycles is entered with N-1 and exits at 0.
  localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_WAIT  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             w_tmr_done;

  logic             r_prev_go;
  logic             w_edge;
  logic [8:0]       w_req_word;

  logic             r_init;
  logic             w_init_nxt;
  logic [1:0]       r_init_idx;
  logic [1:0]       w_init_idx_nxt;

  logic             r_pend_vld;
  logic [8:0]       r_pend_word;
  logic             w_pend_vld_nxt;
  logic [8:0]       w_pend_word_nxt;
  logic             w_pend_take;
  logic             w_direct;
  logic             w_drop;

  logic             w_load_xfer;
  logic [8:0]       w_xfer_nxt;
  logic             w_is_clr;

  logic             w_unused;

  assign w_unused   = ^{i_io_lcd[30:12], i_io_lcd[9]};
  assign o_lcd_rw   = 1'b0;

  assign w_edge     = i_io_lcd[10] & ~r_prev_go;
  assign w_req_word = {i_io_lcd[8], i_io_lcd[7:0]};
  assign w_tmr_done = (r_timer == '0);

  // Clear/home commands need the long execution wait.
  assign w_is_clr   = ~o_lcd_rs &
                      ((o_lcd_data == 8'h01) | (o_lcd_data == 8'h02) | (o_lcd_data == 8'h03));

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Next-state, timer reload, init sequencing and transfer-word selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = w_tmr_done ? r_timer : (r_timer - L_ONE);
    w_load_xfer    = 1'b0;
    w_xfer_nxt     = {o_lcd_rs, o_lcd_data};
    w_init_nxt     = r_init;
    w_init_idx_nxt = r_init_idx;
    w_direct       = 1'b0;
    w_pend_take    = 1'b0;
    case (r_state)
      S_PWRUP: begin
        if (w_tmr_done) begin
          w_state_nxt = S_SETUP;
          w_timer_nxt = L_SETUP;
          w_load_xfer = 1'b1;
          w_xfer_nxt  = {1'b0, init_byte(r_init_idx)};
        end
      end
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_SETUP;
          w_timer_nxt = L_SETUP;
          w_load_xfer = 1'b1;
          w_xfer_nxt  = w_req_word;
          w_direct    = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_tmr_done) begin
          w_state_nxt = S_PULSE;
          w_timer_nxt = L_EN;
        end
      end
      S_PULSE: begin
        if (w_tmr_done) begin
          w_state_nxt = S_HOLD;
          w_timer_nxt = L_HOLD;
        end
      end
      S_HOLD: begin
        if (w_tmr_done) begin
          w_state_nxt = S_WAIT;
          w_timer_nxt = w_is_clr ? L_CLR : L_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tmr_done) begin
          if (r_init) begin
            w_init_idx_nxt = r_init_idx + 2'd1;
            if (r_init_idx != 2'd3) begin
              w_state_nxt = S_SETUP;
              w_timer_nxt = L_SETUP;
              w_load_xfer = 1'b1;
              w_xfer_nxt  = {1'b0, init_byte(r_init_idx + 2'd1)};
            end else begin
              w_init_nxt = 1'b0;
            end
          end
          // Once init is over, serve the buffered request first, then a same-cycle edge.
          if (!r_init || (r_init_idx == 2'd3)) begin
            if (r_pend_vld) begin
              w_state_nxt = S_SETUP;
              w_timer_nxt = L_SETUP;
              w_load_xfer = 1'b1;
              w_xfer_nxt  = r_pend_word;
              w_pend_take = 1'b1;
            end else if (w_edge) begin
              w_state_nxt = S_SETUP;
              w_timer_nxt = L_SETUP;
              w_load_xfer = 1'b1;
              w_xfer_nxt  = w_req_word;
              w_direct    = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_timer_nxt = L_PWRUP;
      end
    endcase
  end

  // Pending buffer: an edge not started directly is buffered if free, otherwise dropped.
  always_comb begin
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_word_nxt = r_pend_word;
    w_drop          = w_edge & ~w_direct & r_pend_vld;
    if (w_pend_take) begin
      w_pend_vld_nxt = 1'b0;
    end else if (w_edge && !w_direct && !r_pend_vld) begin
      w_pend_vld_nxt  = 1'b1;
      w_pend_word_nxt = w_req_word;
    end
  end

  // State, timer, init progress and pending buffer registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_PWRUP;
      r_timer     <= L_PWRUP;
      r_prev_go   <= 1'b0;
      r_init      <= 1'b1;
      r_init_idx  <= 2'd0;
      r_pend_vld  <= 1'b0;
      r_pend_word <= 9'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_prev_go   <= i_io_lcd[10];
      r_init      <= w_init_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_word <= w_pend_word_nxt;
    end
  end

  // Registered LCD pins and status flags, all derived from the next state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_lcd_data <= 8'h00;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_busy     <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      if (w_load_xfer) begin
        o_lcd_rs   <= w_xfer_nxt[8];
        o_lcd_data <= w_xfer_nxt[7:0];
      end
      o_lcd_en <= (w_state_nxt == S_PULSE);
      o_lcd_on <= i_io_lcd[31];
      o_busy   <= ~((w_state_nxt == S_IDLE) & ~w_pend_vld_nxt);
      if (w_drop) begin
        o_overflow <= 1'b1;
      end else if (i_io_lcd[11]) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Testbench for lcd_hd44780_ctrl: randomized and directed LCD register writes against an occupancy model.
// Latency: expected transfers are queued with their SETUP start cycle; EN must rise SETUP cycles later.
// Backpressure: model keeps one pending slot; extra edges are expected to be dropped and set overflow.
module tb_lcd_hd44780_ctrl;

  localparam int SETUP = 2;
  localparam int ENC   = 3;
  localparam int HOLD  = 1;
  localparam int WAITC = 5;
  localparam int CLRC  = 20;
  localparam int PWR   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io = 32'd0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ovf;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC(PWR), .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
    .WAIT_CYC(WAITC), .CLR_CYC(CLRC), .CNT_W(20)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_io_lcd(io),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_busy(busy), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc;

  // Cycle number since reset release (posedge count).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct { logic [8:0] word; int start; } xfer_t;
  typedef struct { int c; logic busy; logic ovf; logic on; } stat_t;

  xfer_t xq[$];
  stat_t sq[$];

  int         m_free_at;
  logic       m_prev_go, m_pend_vld, m_ovf;
  logic [8:0] m_pend_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  function automatic int dur_of(input logic [8:0] w);
    int ex;
    ex = (w[8] == 1'b0 && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) ? CLRC : WAITC;
    return SETUP + ENC + HOLD + ex;
  endfunction

  task automatic m_start(input logic [8:0] w, input int c);
    xfer_t x;
    x.word = w;
    x.start = c;
    xq.push_back(x);
    m_free_at = c + dur_of(w);
  endtask

  task automatic m_reset();
    logic [7:0] ib [4];
    ib = '{8'h38, 8'h0C, 8'h01, 8'h06};
    xq.delete();
    sq.delete();
    m_prev_go = 1'b0;
    m_pend_vld = 1'b0;
    m_pend_word = 9'd0;
    m_ovf = 1'b0;
    m_free_at = PWR;
    for (int i = 0; i < 4; i++) m_start({1'b0, ib[i]}, m_free_at);
  endtask

  // Model for the input value sampled at posedge c.
  task automatic m_step(input int c, input logic [31:0] v);
    logic edge_s, drop;
    stat_t s;
    edge_s = v[10] && !m_prev_go;
    m_prev_go = v[10];
    drop = 1'b0;
    if (c >= m_free_at) begin
      if (m_pend_vld) begin
        m_pend_vld = 1'b0;
        m_start(m_pend_word, c);
        if (edge_s) drop = 1'b1;
      end else if (edge_s) begin
        m_start({v[8], v[7:0]}, c);
      end
    end else if (edge_s) begin
      if (!m_pend_vld) begin
        m_pend_vld = 1'b1;
        m_pend_word = {v[8], v[7:0]};
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (v[11]) m_ovf = 1'b0;
    s.c = c;
    s.busy = (c < m_free_at) || m_pend_vld;
    s.ovf = m_ovf;
    s.on = v[31];
    sq.push_back(s);
  endtask

  task automatic drive_cycle(input logic [31:0] v);
    io = v;
    m_step(cyc + 1, v);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle status and per-transfer scoreboard checks on the negedge.
  initial begin
    logic       prev_en;
    logic [8:0] prev_w, cur_w, rise_w;
    int         last_chg, rise_c;
    stat_t      s;
    xfer_t      x;
    prev_en = 1'b0; prev_w = 9'd0; rise_w = 9'd0; last_chg = 0; rise_c = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0; prev_w = 9'd0; last_chg = 0;
        continue;
      end
      if (cyc == 0) continue;
      if (sq.size() == 0) begin
        fail_now("status_queue_empty");
      end else begin
        s = sq.pop_front();
        chk("stat_cycle", cyc, s.c);
        chk("busy", {31'd0, busy}, {31'd0, s.busy});
        chk("overflow", {31'd0, ovf}, {31'd0, s.ovf});
        chk("lcd_on", {31'd0, lcd_on}, {31'd0, s.on});
        chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      end
      cur_w = {lcd_rs, lcd_data};
      if (cur_w != prev_w) last_chg = cyc;
      prev_w = cur_w;
      if (lcd_en && !prev_en) begin
        if (xq.size() == 0) begin
          fail_now("unexpected_en");
        end else begin
          x = xq.pop_front();
          chk("xfer_word", {23'd0, cur_w}, {23'd0, x.word});
          chk("en_rise_cycle", cyc, x.start + SETUP);
          chk("setup_stable", (cyc - last_chg >= SETUP) ? 32'd1 : 32'd0, 32'd1);
        end
        rise_c = cyc;
        rise_w = cur_w;
      end
      if (!lcd_en && prev_en) begin
        chk("en_width", cyc - rise_c, ENC);
        chk("hold_word", {23'd0, cur_w}, {23'd0, rise_w});
      end
      prev_en = lcd_en;
    end
  end

  // Stimulus: directed scenarios, random traffic, reset during EN pulse, drain.
  initial begin
    logic [31:0] v;
    int k;
    rst_n = 1'b0;
    io = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    m_reset();
    rst_n = 1'b1;

    repeat (80) drive_cycle(32'd0);

    drive_cycle(32'h0000_0541);
    drive_cycle(32'h0000_0141);
    repeat (14) drive_cycle(32'd0);

    drive_cycle(32'h0000_0541);
    drive_cycle(32'h0000_0141);
    drive_cycle(32'h0000_0542);
    repeat (30) drive_cycle(32'd0);

    drive_cycle(32'h0000_0543);
    drive_cycle(32'h0000_0000);
    drive_cycle(32'h0000_0544);
    drive_cycle(32'h0000_0000);
    drive_cycle(32'h0000_0545);
    repeat (30) drive_cycle(32'd0);
    drive_cycle(32'h0000_0800);
    repeat (3) drive_cycle(32'd0);

    drive_cycle(32'h0000_0401);
    drive_cycle(32'h0000_0000);
    drive_cycle(32'h0000_0546);
    repeat (45) drive_cycle(32'd0);

    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      v[10] = ($urandom_range(0, 5) == 0);
      v[11] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        v[8] = 1'b0;
        v[7:0] = 8'($urandom_range(1, 3));
      end
      drive_cycle(v);
    end
    repeat (60) drive_cycle(32'd0);

    drive_cycle(32'h0000_0547);
    drive_cycle(32'h0000_0000);
    drive_cycle(32'h0000_0548);
    for (k = 0; k < 30 && !lcd_en; k++) drive_cycle(32'd0);
    if (!lcd_en) begin
      fail_now("en_wait_timeout");
    end else begin
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_en", {31'd0, lcd_en}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd1);
      chk("midrst_data", {24'd0, lcd_data}, 32'd0);
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    repeat (80) drive_cycle(32'd0);

    for (int i = 0; i < 100; i++) begin
      v = $urandom;
      v[10] = ($urandom_range(0, 4) == 0);
      v[11] = ($urandom_range(0, 7) == 0);
      drive_cycle(v);
    end

    for (k = 0; k < 200 && (xq.size() != 0 || busy); k++) drive_cycle(32'd0);
    if (xq.size() != 0 || busy) fail_now("drain_timeout");
    repeat (2) drive_cycle(32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
